// File: rtl/load_store_unit.sv
`default_nettype none
// ---------------------------------------------------------------------------
// load_store_unit : RV32I data-memory access engine (align, lanes, extend)
// Revision 1.0
// ---------------------------------------------------------------------------
module load_store_unit #(
  parameter int XLEN         = 32,
  parameter int LS_SEL_WIDTH = 3
) (
  input  logic                  i_Clock,
  input  logic                  i_Reset_N,
  input  logic                  i_Start,
  input  logic [LS_SEL_WIDTH:0] i_Load_Store_Type,
  input  logic [XLEN-1:0]       i_Address,
  input  logic [XLEN-1:0]       i_Store_Data,
  output logic                  o_Busy,
  output logic                  o_Done,
  output logic                  o_Misaligned,
  output logic [XLEN-1:0]       o_Load_Data,
  output logic                  o_Mem_Valid,
  output logic                  o_Mem_Write,
  output logic [XLEN-1:0]       o_Mem_Address,
  output logic [XLEN-1:0]       o_Mem_Write_Data,
  output logic [3:0]            o_Mem_Byte_Enable,
  input  logic                  i_Mem_Ready,
  input  logic                  i_Mem_Read_Valid,
  input  logic [XLEN-1:0]       i_Mem_Read_Data
);

  // Type code layout: bit3 = store, bit2 = unsigned load, bits[1:0] = size.
  localparam logic [LS_SEL_WIDTH:0] LS_TYPE_NONE = (LS_SEL_WIDTH+1)'(4'h0);
  localparam logic [LS_SEL_WIDTH:0] LS_TYPE_LB   = (LS_SEL_WIDTH+1)'(4'h1);
  localparam logic [LS_SEL_WIDTH:0] LS_TYPE_LH   = (LS_SEL_WIDTH+1)'(4'h2);
  localparam logic [LS_SEL_WIDTH:0] LS_TYPE_LW   = (LS_SEL_WIDTH+1)'(4'h3);
  localparam logic [LS_SEL_WIDTH:0] LS_TYPE_LBU  = (LS_SEL_WIDTH+1)'(4'h5);
  localparam logic [LS_SEL_WIDTH:0] LS_TYPE_LHU  = (LS_SEL_WIDTH+1)'(4'h6);
  localparam logic [LS_SEL_WIDTH:0] LS_TYPE_SB   = (LS_SEL_WIDTH+1)'(4'h9);
  localparam logic [LS_SEL_WIDTH:0] LS_TYPE_SH   = (LS_SEL_WIDTH+1)'(4'hA);
  localparam logic [LS_SEL_WIDTH:0] LS_TYPE_SW   = (LS_SEL_WIDTH+1)'(4'hB);

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    REQUEST   = 2'd1,
    WAIT_READ = 2'd2,
    DONE      = 2'd3
  } state_t;

  state_t                  state_q;
  logic [LS_SEL_WIDTH:0]   type_q;
  logic [1:0]              offset_q;
  logic                    busy_q, done_q, misaligned_q;
  logic [XLEN-1:0]         load_data_q;
  logic                    mem_valid_q, mem_write_q;
  logic [XLEN-1:0]         mem_addr_q, mem_wdata_q;
  logic [3:0]              mem_be_q;

  logic                    type_ok_d, is_store_d, misaligned_d;
  logic [1:0]              size_d;
  logic [3:0]              be_d;
  logic [XLEN-1:0]         wdata_d, load_data_d;
  logic [7:0]              rd_byte;
  logic [15:0]             rd_half;

  always_comb begin
    type_ok_d  = 1'b1;
    is_store_d = 1'b0;
    size_d     = SIZE_BYTE;
    case (i_Load_Store_Type)
      LS_TYPE_LB, LS_TYPE_LBU: size_d = SIZE_BYTE;
      LS_TYPE_LH, LS_TYPE_LHU: size_d = SIZE_HALF;
      LS_TYPE_LW:              size_d = SIZE_WORD;
      LS_TYPE_SB: begin size_d = SIZE_BYTE; is_store_d = 1'b1; end
      LS_TYPE_SH: begin size_d = SIZE_HALF; is_store_d = 1'b1; end
      LS_TYPE_SW: begin size_d = SIZE_WORD; is_store_d = 1'b1; end
      default:    type_ok_d = 1'b0;
    endcase

    misaligned_d = ((size_d == SIZE_HALF) && i_Address[0]) ||
                   ((size_d == SIZE_WORD) && (i_Address[1:0] != 2'b00));

    case (size_d)
      SIZE_BYTE: begin
        be_d    = 4'b0001 << i_Address[1:0];
        wdata_d = {(XLEN/8){i_Store_Data[7:0]}};
      end
      SIZE_HALF: begin
        be_d    = 4'b0011 << i_Address[1:0];
        wdata_d = {(XLEN/16){i_Store_Data[15:0]}};
      end
      default: begin
        be_d    = 4'b1111;
        wdata_d = i_Store_Data;
      end
    endcase
  end

  // Lane extraction uses the offset captured at start, not the live address.
  assign rd_byte = i_Mem_Read_Data[{offset_q, 3'b000} +: 8];
  assign rd_half = i_Mem_Read_Data[{offset_q[1], 4'b0000} +: 16];

  always_comb begin
    load_data_d = i_Mem_Read_Data;
    case (type_q)
      LS_TYPE_LB:  load_data_d = {{(XLEN-8){rd_byte[7]}}, rd_byte};
      LS_TYPE_LBU: load_data_d = {{(XLEN-8){1'b0}}, rd_byte};
      LS_TYPE_LH:  load_data_d = {{(XLEN-16){rd_half[15]}}, rd_half};
      LS_TYPE_LHU: load_data_d = {{(XLEN-16){1'b0}}, rd_half};
      default:     load_data_d = i_Mem_Read_Data;
    endcase
  end

  always_ff @(posedge i_Clock or negedge i_Reset_N) begin
    if (!i_Reset_N) begin
      state_q      <= IDLE;
      type_q       <= LS_TYPE_NONE;
      offset_q     <= 2'b00;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      misaligned_q <= 1'b0;
      load_data_q  <= '0;
      mem_valid_q  <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_be_q     <= 4'b0000;
    end else begin
      done_q       <= 1'b0;
      misaligned_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (i_Start && type_ok_d) begin
            type_q   <= i_Load_Store_Type;
            offset_q <= i_Address[1:0];
            busy_q   <= 1'b1;
            if (misaligned_d) begin
              state_q      <= DONE;
              done_q       <= 1'b1;
              misaligned_q <= 1'b1;
            end else begin
              state_q     <= REQUEST;
              mem_valid_q <= 1'b1;
              mem_write_q <= is_store_d;
              mem_addr_q  <= {i_Address[XLEN-1:2], 2'b00};
              mem_wdata_q <= wdata_d;
              mem_be_q    <= be_d;
            end
          end
        end
        REQUEST: begin
          if (i_Mem_Ready) begin
            mem_valid_q <= 1'b0;
            if (mem_write_q) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= WAIT_READ;
            end
          end
        end
        WAIT_READ: begin
          if (i_Mem_Read_Valid) begin
            load_data_q <= load_data_d;
            state_q     <= DONE;
            done_q      <= 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign o_Busy            = busy_q;
  assign o_Done            = done_q;
  assign o_Misaligned      = misaligned_q;
  assign o_Load_Data       = load_data_q;
  assign o_Mem_Valid       = mem_valid_q;
  assign o_Mem_Write       = mem_write_q;
  assign o_Mem_Address     = mem_addr_q;
  assign o_Mem_Write_Data  = mem_wdata_q;
  assign o_Mem_Byte_Enable = mem_be_q;

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// tb_load_store_unit : directed plus randomized checks against an arithmetic
// model of lane selection, alignment and load extension.
module tb_load_store_unit;

  localparam logic [3:0] T_NONE = 4'h0, T_LB = 4'h1, T_LH = 4'h2, T_LW = 4'h3,
                         T_LBU = 4'h5, T_LHU = 4'h6, T_SB = 4'h9, T_SH = 4'hA,
                         T_SW = 4'hB;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  ls_type = 4'h0;
  logic [31:0] addr = '0, sdata = '0;
  logic        busy, done, misaligned, mem_valid, mem_write;
  logic [31:0] load_data, mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ready = 1'b0, rd_valid = 1'b0;
  logic [31:0] rd_data = '0;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] model_load = '0;

  always #5 clk = ~clk;

  load_store_unit dut (
    .i_Clock(clk), .i_Reset_N(rst_n), .i_Start(start),
    .i_Load_Store_Type(ls_type), .i_Address(addr), .i_Store_Data(sdata),
    .o_Busy(busy), .o_Done(done), .o_Misaligned(misaligned),
    .o_Load_Data(load_data), .o_Mem_Valid(mem_valid), .o_Mem_Write(mem_write),
    .o_Mem_Address(mem_addr), .o_Mem_Write_Data(mem_wdata),
    .o_Mem_Byte_Enable(mem_be), .i_Mem_Ready(mem_ready),
    .i_Mem_Read_Valid(rd_valid), .i_Mem_Read_Data(rd_data)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int size_of(input logic [3:0] t);
    case (t)
      T_LB, T_LBU, T_SB: return 1;
      T_LH, T_LHU, T_SH: return 2;
      default:           return 4;
    endcase
  endfunction

  function automatic bit is_store(input logic [3:0] t);
    return (t == T_SB) || (t == T_SH) || (t == T_SW);
  endfunction

  function automatic logic [31:0] exp_load(input logic [3:0] t, input logic [31:0] a,
                                           input logic [31:0] rd);
    int unsigned off, v;
    off = a % 4;
    v = rd >> (8 * off);
    case (t)
      T_LB:  begin v = v % 256;   if (v >= 128)   v = v + 32'hFFFF_FF00; end
      T_LBU: v = v % 256;
      T_LH:  begin v = v % 65536; if (v >= 32768) v = v + 32'hFFFF_0000; end
      T_LHU: v = v % 65536;
      default: v = rd;
    endcase
    return v;
  endfunction

  function automatic logic [3:0] exp_be(input logic [3:0] t, input logic [31:0] a);
    int sz;
    sz = size_of(t);
    if (sz == 4) return 4'hF;
    return 4'(((1 << sz) - 1) << (a % 4));
  endfunction

  function automatic logic [31:0] exp_wdata(input logic [3:0] t, input logic [31:0] d);
    case (size_of(t))
      1:       return (d % 256) * 32'h0101_0101;
      2:       return (d % 65536) * 32'h0001_0001;
      default: return d;
    endcase
  endfunction

  // Runs one access from an IDLE cycle; optionally pokes i_Start while busy.
  task automatic access(input logic [3:0] t, input logic [31:0] a, input logic [31:0] d,
                        input int rdy_dly, input int rv_dly, input logic [31:0] rdw,
                        input bit poke);
    bit mis;
    mis = (a % size_of(t)) != 0;
    chk("idle_busy", busy, 1'b0);
    start = 1'b1; ls_type = t; addr = a; sdata = d;
    tick();
    start = poke; ls_type = poke ? T_SW : T_NONE; addr = 32'h0000_0044;
    if (mis) begin
      chk("mis_done", done, 1'b1);
      chk("mis_flag", misaligned, 1'b1);
      chk("mis_valid", mem_valid, 1'b0);
      start = 1'b0;
    end else begin
      for (int i = 0; i <= rdy_dly; i++) begin
        chk("req_valid", mem_valid, 1'b1);
        chk("req_write", mem_write, is_store(t));
        chk("req_addr", mem_addr, a & 32'hFFFF_FFFC);
        chk("req_be", mem_be, exp_be(t, a));
        if (is_store(t)) chk("req_wdata", mem_wdata, exp_wdata(t, d));
        chk("req_nodone", done, 1'b0);
        mem_ready = (i == rdy_dly);
        rd_valid  = (i == rdy_dly);
        rd_data   = ~rdw;
        tick();
      end
      mem_ready = 1'b0; rd_valid = 1'b0;
      if (!is_store(t)) begin
        for (int j = 0; j <= rv_dly; j++) begin
          chk("wait_valid", mem_valid, 1'b0);
          chk("wait_nodone", done, 1'b0);
          chk("wait_busy", busy, 1'b1);
          rd_valid = (j == rv_dly);
          rd_data  = (j == rv_dly) ? rdw : $urandom;
          tick();
        end
        rd_valid = 1'b0;
        model_load = exp_load(t, a, rdw);
      end
      start = 1'b0;
      chk("acc_done", done, 1'b1);
      chk("acc_nomis", misaligned, 1'b0);
      chk("acc_valid", mem_valid, 1'b0);
    end
    chk("done_busy", busy, 1'b1);
    chk("load_data", load_data, model_load);
    tick();
    chk("post_done", done, 1'b0);
    chk("post_busy", busy, 1'b0);
    chk("post_mis", misaligned, 1'b0);
    chk("post_load", load_data, model_load);
  endtask

  initial begin
    logic [3:0] types [9];
    types = '{T_LB, T_LH, T_LW, T_LBU, T_LHU, T_SB, T_SH, T_SW, T_NONE};

    #12;
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_valid", mem_valid, 1'b0);
    chk("rst_load", load_data, 32'h0);
    chk("rst_be", {28'h0, mem_be}, 32'h0);
    @(negedge clk); rst_n = 1'b1;
    tick();

    // Store byte at the top lane.
    access(T_SB, 32'h0000_1003, 32'hAABB_CCDD, 0, 0, 32'h0, 1'b0);

    // Load extension of one read word at several offsets.
    access(T_LB, 32'h0000_2001, 32'h0, 0, 0, 32'h80FF_7F01, 1'b0);
    chk("lb_const", load_data, 32'h0000_007F);
    access(T_LH, 32'h0000_2002, 32'h0, 0, 0, 32'h80FF_7F01, 1'b0);
    chk("lh_const", load_data, 32'hFFFF_80FF);
    access(T_LHU, 32'h0000_2002, 32'h0, 0, 0, 32'h80FF_7F01, 1'b0);
    chk("lhu_const", load_data, 32'h0000_80FF);
    access(T_LW, 32'h0000_2000, 32'h0, 0, 0, 32'h80FF_7F01, 1'b0);
    chk("lw_const", load_data, 32'h80FF_7F01);

    // Wait states with start poked while busy.
    access(T_LW, 32'h0000_3000, 32'h0, 3, 1, 32'h1234_5678, 1'b1);

    // Misaligned accesses leave load data untouched.
    access(T_LW, 32'h0000_1002, 32'h0, 0, 0, 32'h0, 1'b0);
    access(T_SH, 32'h0000_1001, 32'h5555_AAAA, 0, 0, 32'h0, 1'b0);
    chk("mis_keep", load_data, 32'h1234_5678);

    // Ignored starts: NONE and an undefined code.
    start = 1'b1; ls_type = T_NONE; addr = 32'h100;
    tick();
    ls_type = 4'hF;
    tick();
    start = 1'b0;
    chk("ign_busy", busy, 1'b0);
    chk("ign_valid", mem_valid, 1'b0);
    chk("ign_done", done, 1'b0);
    tick();
    chk("ign_done2", done, 1'b0);

    // Randomized accesses.
    for (int n = 0; n < 60; n++) begin
      logic [3:0] t;
      logic [31:0] a;
      t = types[$urandom_range(0, 7)];
      a = $urandom;
      if ($urandom_range(0, 1) == 0) a = a & 32'hFFFF_FFFC | 32'(size_of(t) == 1 ? $urandom_range(0, 3) : 0);
      access(t, a, $urandom, $urandom_range(0, 3), $urandom_range(0, 3), $urandom, $urandom_range(0, 1) == 1);
    end

    // Reset during WAIT_READ.
    start = 1'b1; ls_type = T_LW; addr = 32'h0000_4000;
    tick();
    start = 1'b0;
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    chk("rr_wait", mem_valid, 1'b0);
    chk("rr_busy", busy, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("rr_busy0", busy, 1'b0);
    chk("rr_valid0", mem_valid, 1'b0);
    chk("rr_addr0", mem_addr, 32'h0);
    chk("rr_load0", load_data, 32'h0);
    @(negedge clk); rst_n = 1'b1;
    model_load = '0;
    tick();
    rd_valid = 1'b1; rd_data = 32'hDEAD_BEEF;
    tick();
    rd_valid = 1'b0;
    chk("rr_nodone", done, 1'b0);
    chk("rr_load", load_data, 32'h0);
    tick();
    chk("rr_nodone2", done, 1'b0);
    chk("rr_idle", busy, 1'b0);

    // Back-to-back after reset still works.
    access(T_LBU, 32'h0000_5003, 32'h0, 0, 0, 32'hC3B2_A190, 1'b0);
    chk("final_lbu", load_data, 32'h0000_00C3);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
